// File: rtl/rv32_pkg.sv
// Shared RV32 fetch/decode definitions: NOP bubble encoding and the fetch queue entry.
// Used by ifq_fetch_queue and by the decoder for bubble insertion.
package rv32_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ptr.sv
// Wrap-around pointer register with synchronous clear and advance enable.
// Width equals log2 of a power-of-two depth, so natural overflow gives the modulo wrap.
module ifq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (clr)
            ptr <= '0;
        else if (en)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/ifq_fetch_queue.sv
// In-order {pc, instr} queue between fetch and the IF->ID register; NOP on empty cycles.
// Optional empty-queue bypass from in_* to out_* is enabled by defining IFQ_BYPASS_EN.
module ifq_fetch_queue
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 32,
    parameter int IW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PW-1:0]            in_pc,
    input  logic [IW-1:0]            in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PW-1:0]            out_pc,
    output logic [IW-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] pc_mem    [DEPTH];
    logic [IW-1:0] instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, push, pop, wr_en, rd_en, byp;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full;

`ifdef IFQ_BYPASS_EN
    // Empty queue forwards the fetch pair directly; flush kills it this cycle.
    assign byp       = empty & in_valid & !flush;
    assign out_valid = !empty | byp;
    assign out_pc    = byp ? in_pc    : (empty ? '0           : pc_mem[rd_ptr]);
    assign out_instr = byp ? in_instr : (empty ? IW'(NOP_INSTR) : instr_mem[rd_ptr]);
`else
    assign byp       = 1'b0;
    assign out_valid = !empty;
    assign out_pc    = empty ? '0             : pc_mem[rd_ptr];
    assign out_instr = empty ? IW'(NOP_INSTR) : instr_mem[rd_ptr];
`endif

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    // A bypassed pair consumed by decode is never written into storage.
    assign wr_en = push & !flush & !(byp & out_ready);
    assign rd_en = pop & !empty & !flush;

    // Clearing both pointers on flush leaves rd_ptr == wr_ptr with nothing queued.
    ifq_ptr #(.W(AW)) u_wr_ptr (
        .clk (clk),
        .clr (rst | flush),
        .en  (wr_en),
        .ptr (wr_ptr)
    );

    ifq_ptr #(.W(AW)) u_rd_ptr (
        .clk (clk),
        .clr (rst | flush),
        .en  (rd_en),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || flush)
            count <= '0;
        else
            count <= count + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_ifq_fetch_queue.sv
// Self-checking bench for ifq_fetch_queue: queue-based reference model, directed scenarios, random traffic.
// Build with IFQ_BYPASS_EN defined to exercise the bypass variant.
module tb_ifq_fetch_queue;
    import rv32_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;

    ifq_fetch_queue #(.DEPTH(DEPTH), .PW(32), .IW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] emitted[$];
    bit          chk_en = 1'b0;

    function automatic bit was_emitted(input logic [31:0] p, input int from);
        for (int i = from; i < emitted.size(); i++)
            if (emitted[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every cycle against what the queue contents say decode should see.
    always @(negedge clk) begin
        logic        ev;
        logic [31:0] epc, ein;
        if (chk_en) begin
            ev  = (q.size() != 0);
            epc = ev ? q[0].pc : 32'h0;
            ein = ev ? q[0].instr : 32'h0000_0013;
            if (BYP && q.size() == 0 && in_valid && !flush) begin
                ev  = 1'b1;
                epc = in_pc;
                ein = in_instr;
            end
            chk("count", count, q.size());
            chk("in_ready", in_ready, q.size() != DEPTH);
            chk("out_valid", out_valid, ev);
            chk("out_pc", out_pc, epc);
            chk("out_instr", out_instr, ein);
        end
    end

    // Reference model state update.
    always @(posedge clk) begin
        int   n;
        bit   bv;
        ent_t e;
        if (rst || flush) begin
            q.delete();
        end else begin
            n  = q.size();
            bv = BYP && n == 0 && in_valid;
            if (out_ready && (n != 0 || bv))
                emitted.push_back(n != 0 ? q[0].pc : in_pc);
            if (out_ready && n != 0)
                void'(q.pop_front());
            if (in_valid && n != DEPTH && !(bv && out_ready)) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = pc | 32'h100;
        out_ready = rdy;
    endtask

    initial begin
        int base, maxc;

        // 1. reset with fetch active
        rst = 1'b1;
        drive(1'b1, 32'h1000, 1'b0);
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_in_ready", in_ready, 1);

        // 2. fill then drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0);
            step();
        end
        chk("fill_count", count, 4);
        chk("fill_in_ready", in_ready, 0);
        drive(1'b1, 32'h10, 1'b0);
        step();
        chk("fifth_rejected", count, 4);
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_out_pc", out_pc, 32'(4 * i));
            step();
        end
        chk("drain_empty", out_valid, 0);
        chk("fifth_never_out", was_emitted(32'h10, 0), 0);

        // 3. back-to-back through the pointer wrap
        base = emitted.size();
        maxc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b1);
            step();
            if (int'(count) > maxc) maxc = int'(count);
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        step();
        chk("wrap_max_count", maxc, BYP ? 0 : 1);
        chk("wrap_emit_count", emitted.size() - base, 10);
        if (emitted.size() - base >= 10)
            for (int i = 0; i < 10; i++)
                chk("wrap_order", emitted[base + i], 32'h200 + 32'(4 * i));

        // 4. flush with 3 queued plus a same-cycle push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
            step();
        end
        base = emitted.size();
        flush = 1'b1;
        drive(1'b1, 32'h40, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        step();
        step();
        chk("flush_nothing_out", emitted.size() - base, 0);
        chk("flush_pc40_dropped", was_emitted(32'h40, 0), 0);

        // 5. full with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b0);
            step();
        end
        base = emitted.size();
        drive(1'b1, 32'h500, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("fullpop_count", count, 3);
        chk("fullpop_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) step();
        chk("fullpop_emitted", emitted.size() - base, 4);
        chk("fullpop_reject", was_emitted(32'h500, base), 0);

`ifdef IFQ_BYPASS_EN
        // 6. bypass on an empty queue
        drive(1'b1, 32'h80, 1'b1);
        #1;
        chk("byp_out_valid", out_valid, 1);
        chk("byp_out_pc", out_pc, 32'h80);
        step();
        drive(1'b0, 32'h0, 1'b0);
        chk("byp_count", count, 0);
`endif

        // random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_instr  = $urandom;
            step();
        end
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) step();
        chk("final_empty", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
